// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: word-addressed 32-bit register-file slave on the simplified AHB bus.
// One instance per slave slot, selected when sel == SLAVE_ID and hready is high.
// Reads are registered (hrdata updates on the completing edge). WAIT_STATES adds
// a programmable number of stall cycles before the access is committed.
// Optional feature macro: AHB_SLAVE_ERR_EN. When defined, a hit whose address has
// any bit set above the word index returns a two-cycle error response (ERR1/ERR2).
// When undefined, hresp is tied low and the upper address bits alias.

module ahb_slave_mem #(
    parameter logic [3:0] SLAVE_ID    = 4'b0001,
    parameter int         ADDR_WIDTH  = 6,
    parameter int         WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [3:0]  sel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    // Counter reload: the hit edge itself accounts for one of the WAIT_STATES+1 cycles.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef AHB_SLAVE_ERR_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1
    } state_t;
`endif

    state_t state, state_nxt;

    logic [3:0]            wcnt, wcnt_nxt;
    logic                  rdy_nxt;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] word_in;

    // Access latched at the hit edge when wait states are configured
    logic [ADDR_WIDTH-1:0] lat_word;
    logic                  lat_write;
    logic [DATA_W-1:0]     lat_wdata;
    logic                  lat_en;

    // The access that commits at the current edge, from the bus or from the latch
    logic                  acc_en;
    logic [ADDR_WIDTH-1:0] acc_word;
    logic                  acc_write;
    logic [DATA_W-1:0]     acc_wdata;

    logic [DATA_W-1:0]     mem_rd [DEPTH];

    // Byte-lane bits never take part in decoding; upper bits only matter with the error check
    logic                  unused_addr;
    assign unused_addr = ^{haddr[1:0], haddr[31:ADDR_WIDTH+2]};

    assign hit     = hready && (sel == SLAVE_ID);
    assign word_in = haddr[ADDR_WIDTH+1:2];

`ifdef AHB_SLAVE_ERR_EN
    logic addr_err;
    logic resp_nxt;
    assign addr_err = |haddr[31:ADDR_WIDTH+2];
`endif

    // State register plus the registered handshake outputs; reset drops any pending access
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            hreadyout <= 1'b1;
`ifdef AHB_SLAVE_ERR_EN
            hresp     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            hreadyout <= rdy_nxt;
`ifdef AHB_SLAVE_ERR_EN
            hresp     <= resp_nxt;
`endif
        end
    end

`ifndef AHB_SLAVE_ERR_EN
    assign hresp = 1'b0;
`endif

    // Next-state decode: selects the committing access and the next handshake values
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        rdy_nxt   = 1'b1;
        lat_en    = 1'b0;
        acc_en    = 1'b0;
        acc_word  = word_in;
        acc_write = hwrite;
        acc_wdata = hwdata;
`ifdef AHB_SLAVE_ERR_EN
        resp_nxt  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (hit) begin
`ifdef AHB_SLAVE_ERR_EN
                    if (addr_err) begin
                        state_nxt = S_ERR1;
                        rdy_nxt   = 1'b0;
                        resp_nxt  = 1'b1;
                    end else
`endif
                    if (WAIT_STATES == 0) begin
                        acc_en = 1'b1;
                    end else begin
                        lat_en    = 1'b1;
                        wcnt_nxt  = WS_LOAD;
                        rdy_nxt   = 1'b0;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                acc_word  = lat_word;
                acc_write = lat_write;
                acc_wdata = lat_wdata;
                if (wcnt == 4'd0) begin
                    acc_en    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                    rdy_nxt  = 1'b0;
                end
            end
`ifdef AHB_SLAVE_ERR_EN
            S_ERR1: begin
                resp_nxt  = 1'b1;
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                state_nxt = S_IDLE;
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the write flag at the hit edge; bus inputs are ignored afterwards
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            lat_write <= 1'b0;
        end else if (lat_en) begin
            lat_write <= hwrite;
        end
    end

    // Capture word index and write data at the hit edge
    always_ff @(posedge hclk) begin
        if (lat_en) begin
            lat_word  <= word_in;
            lat_wdata <= hwdata;
        end
    end

    // Storage: one register per word, cleared by reset, written by the committing access
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] word_q;

        always_ff @(posedge hclk or negedge hresetn) begin
            if (!hresetn) begin
                word_q <= '0;
            end else if (acc_en && acc_write && (acc_word == ADDR_WIDTH'(i))) begin
                word_q <= acc_wdata;
            end
        end

        assign mem_rd[i] = word_q;
    end

    // Registered read data; holds its value whenever no read commits
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hrdata <= '0;
        end else if (acc_en && !acc_write) begin
            hrdata <= mem_rd[acc_word];
        end
    end

endmodule
